// File: rtl/miri_dcache_pkg.sv
// miri_dcache_pkg: shared encodings and line geometry for the MIRI data cache
package miri_dcache_pkg;
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2
    } state_t;

    localparam logic [1:0] RW_LDB = 2'b00;
    localparam logic [1:0] RW_LDW = 2'b01;
    localparam logic [1:0] RW_STB = 2'b10;
    localparam logic [1:0] RW_STW = 2'b11;

    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 4;
endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/dirty/tag/data arrays with combinational read, byte/word store and line fill
module dcache_line_store
    import miri_dcache_pkg::*;
#(
    parameter int LINES = 4,
    parameter int TAG_W = 26
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(LINES)-1:0]   i_rd_idx,
    output logic                       o_valid,
    output logic                       o_dirty,
    output logic [TAG_W-1:0]           o_tag,
    output logic [LINE_BYTES*8-1:0]    o_data,
    input  logic                       i_st_en,
    input  logic                       i_st_word,
    input  logic [OFFSET_W-1:0]        i_st_off,
    input  logic [31:0]                i_st_data,
    input  logic [$clog2(LINES)-1:0]   i_ln_idx,
    input  logic                       i_clr_dirty,
    input  logic                       i_fill_en,
    input  logic [TAG_W-1:0]           i_fill_tag,
    input  logic [LINE_BYTES*8-1:0]    i_fill_data
);
    logic [LINES-1:0]          r_valid;
    logic [LINES-1:0]          r_dirty;
    logic [TAG_W-1:0]          r_tag  [LINES];
    logic [LINE_BYTES*8-1:0]   r_data [LINES];

    assign o_valid = r_valid[i_rd_idx];
    assign o_dirty = r_dirty[i_rd_idx];
    assign o_tag   = r_tag[i_rd_idx];
    assign o_data  = r_data[i_rd_idx];

    // Line status: reset invalidates everything; stores dirty, writeback and fill clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_clr_dirty) r_dirty[i_ln_idx] <= 1'b0;
            if (i_fill_en) begin
                r_valid[i_ln_idx] <= 1'b1;
                r_dirty[i_ln_idx] <= 1'b0;
            end
            if (i_st_en) r_dirty[i_rd_idx] <= 1'b1;
        end
    end

    // Tag and data payload: whole-line fill or a single byte/word store lane
    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[i_ln_idx]  <= i_fill_tag;
            r_data[i_ln_idx] <= i_fill_data;
        end else if (i_st_en) begin
            if (i_st_word) r_data[i_rd_idx][{i_st_off[3:2], 5'b0} +: 32] <= i_st_data;
            else           r_data[i_rd_idx][{i_st_off, 3'b0} +: 8]       <= i_st_data[7:0];
        end
    end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache; DCACHE_STATS_EN adds hit/miss counters
module dcache_ctrl
    import miri_dcache_pkg::*;
#(
    parameter int LINES  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dc_req,
    input  logic [1:0]           DC_rd_wr,
    input  logic                 DC_we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 dCacheMiss,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [127:0]         mem_wdata,
    input  logic [127:0]         mem_rdata,
    input  logic                 mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);
    localparam int IW    = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFFSET_W - IW;
    localparam int LA_W  = ADDR_W - OFFSET_W;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [127:0]        r_mem_wdata;
    logic [LA_W-1:0]     r_fill_line;
    logic [IW-1:0]       w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_valid;
    logic                w_dirty;
    logic [TAG_W-1:0]    w_vtag;
    logic [127:0]        w_line;
    logic                w_idle;
    logic                w_hit;
    logic                w_miss;
    logic                w_is_store;
    logic                w_is_word;
    logic                w_load_hit;
    logic                w_store_hit;
    logic [31:0]         w_word;
    logic [7:0]          w_byte;
    logic                w_clr_dirty;
    logic                w_fill_en;

    assign w_idx       = addr[OFFSET_W +: IW];
    assign w_tag       = addr[ADDR_W-1 -: TAG_W];
    assign w_idle      = r_state == ST_IDLE;
    assign w_is_store  = DC_rd_wr == RW_STB || DC_rd_wr == RW_STW;
    assign w_is_word   = DC_rd_wr == RW_LDW || DC_rd_wr == RW_STW;
    assign w_hit       = dc_req && w_valid && w_vtag == w_tag;
    assign w_miss      = dc_req && !w_hit;
    // Hits only act in IDLE: mid-miss the request is not re-sampled
    assign w_load_hit  = w_idle && w_hit && !w_is_store;
    assign w_store_hit = w_idle && w_hit && w_is_store && DC_we;
    assign w_word      = w_line[{addr[3:2], 5'b0} +: 32];
    assign w_byte      = w_line[{addr[3:0], 3'b0} +: 8];
    assign rdata       = !w_load_hit ? '0 : w_is_word ? w_word : {{24{w_byte[7]}}, w_byte};
    assign dCacheMiss  = w_miss || !w_idle;
    assign mem_req     = !w_idle;
    assign mem_we      = r_state == ST_WRITEBACK;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign w_clr_dirty = r_state == ST_WRITEBACK && mem_ready;
    assign w_fill_en   = r_state == ST_FILL && mem_ready;

    dcache_line_store #(.LINES(LINES), .TAG_W(TAG_W)) u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rd_idx    (w_idx),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tag       (w_vtag),
        .o_data      (w_line),
        .i_st_en     (w_store_hit),
        .i_st_word   (w_is_word),
        .i_st_off    (addr[OFFSET_W-1:0]),
        .i_st_data   (wdata),
        .i_ln_idx    (r_fill_line[IW-1:0]),
        .i_clr_dirty (w_clr_dirty),
        .i_fill_en   (w_fill_en),
        .i_fill_tag  (r_fill_line[LA_W-1:IW]),
        .i_fill_data (mem_rdata)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state: dirty victims are written back before the fill
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:      if (w_miss) w_next = (w_valid && w_dirty) ? ST_WRITEBACK : ST_FILL;
            ST_WRITEBACK: if (mem_ready) w_next = ST_FILL;
            ST_FILL:      if (mem_ready) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    // Memory-side address/data latched at miss entry and held until mem_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_fill_line <= '0;
        end else if (w_idle && w_miss) begin
            r_fill_line <= addr[ADDR_W-1:OFFSET_W];
            r_mem_addr  <= (w_valid && w_dirty) ? {w_vtag, w_idx, {OFFSET_W{1'b0}}}
                                                : {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            r_mem_wdata <= w_line;
        end else if (w_clr_dirty) begin
            r_mem_addr  <= {r_fill_line, {OFFSET_W{1'b0}}};
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Free-running hit and miss-entry counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_load_hit || w_store_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_idle && w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized and directed checks of dcache_ctrl against a line-level cache/memory model
module tb_dcache_ctrl;
    logic         clk;
    logic         rst_n;
    logic         dc_req;
    logic [1:0]   DC_rd_wr;
    logic         DC_we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         dCacheMiss;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] memm    [logic [31:0]];
    logic [127:0] ref_mem [logic [31:0]];
    bit           m_valid [4];
    bit           m_dirty [4];
    logic [25:0]  m_tag   [4];
    logic [127:0] m_data  [4];
    logic [31:0]  wb_q_addr [$];
    logic [127:0] wb_q_data [$];
    logic [31:0]  fill_q    [$];
    bit           mem_auto  = 1;
    bit           pulse_req = 0;
    logic [31:0]  last_rd;
    logic [31:0]  last_wb_addr;
    logic [127:0] last_wb_data;
    int           last_cyc;

    dcache_ctrl #(.LINES(4), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dc_req     (dc_req),
        .DC_rd_wr   (DC_rd_wr),
        .DC_we      (DC_we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .dCacheMiss (dCacheMiss),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] init_line(input logic [31:0] a);
        return {a ^ 32'hC0DE0083, a ^ 32'h5A5A0002, ~a, a ^ 32'h80808001};
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] a);
        return memm.exists(a) ? memm[a] : init_line(a);
    endfunction

    function automatic logic [127:0] ref_line(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    // Line-wide memory responder with random latency and handshake-stability checks
    initial begin
        bit busy = 0;
        bit prev_fill = 0;
        int lat = 0;
        logic [31:0]  s_addr = '0;
        logic         s_we = 0;
        logic [127:0] s_wd = '0;
        mem_ready = 0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 0;
            if (prev_fill) begin
                n_checks++;
                if (mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL req_drop: mem_req=%b after fill ready, expected 0", mem_req);
                end
            end
            prev_fill = 0;
            if (!rst_n) busy = 0;
            else if (pulse_req) begin
                mem_ready = 1;
                mem_rdata = {4{32'hDEADBEEF}};
                pulse_req = 0;
            end else if (mem_auto && mem_req) begin
                if (!busy) begin
                    busy   = 1;
                    lat    = $urandom_range(0, 3);
                    s_addr = mem_addr;
                    s_we   = mem_we;
                    s_wd   = mem_wdata;
                end else begin
                    n_checks++;
                    if ({mem_addr, mem_we, mem_wdata} !== {s_addr, s_we, s_wd}) begin
                        n_fail++;
                        $display("FAIL hold: addr=%h we=%b got, held addr=%h we=%b expected", mem_addr, mem_we, s_addr, s_we);
                    end
                end
                if (lat == 0) begin
                    busy = 0;
                    mem_ready = 1;
                    if (s_we) begin
                        memm[s_addr] = s_wd;
                        wb_q_addr.push_back(s_addr);
                        wb_q_data.push_back(s_wd);
                    end else begin
                        mem_rdata = mem_line(s_addr);
                        fill_q.push_back(s_addr);
                        prev_fill = 1;
                    end
                end else lat--;
            end
        end
    end

    // One access, predicted by the line-level model and run to completion
    task automatic access(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] wd);
        logic [1:0]   idx = a[5:4];
        logic [25:0]  tg = a[31:6];
        logic [31:0]  ln = {a[31:4], 4'b0};
        logic [31:0]  wba;
        logic [127:0] wbd;
        logic [127:0] l;
        logic [127:0] mask;
        logic [31:0]  exp_rd;
        int           sh;
        int           cyc = 0;
        bit           exp_miss;
        bit           exp_wb;
        exp_miss = !(m_valid[idx] && m_tag[idx] == tg);
        exp_wb   = exp_miss && m_valid[idx] && m_dirty[idx];
        wba = {m_tag[idx], idx, 4'b0};
        wbd = m_data[idx];
        wb_q_addr.delete();
        wb_q_data.delete();
        fill_q.delete();
        @(negedge clk);
        dc_req = 1; DC_rd_wr = rw; addr = a; wdata = wd; DC_we = rw[1];
        #1;
        n_checks++;
        if (dCacheMiss !== exp_miss) begin
            n_fail++;
            $display("FAIL miss_flag @%h: dCacheMiss=%b expected %b", a, dCacheMiss, exp_miss);
        end
        while (dCacheMiss === 1'b1 && cyc < 40) begin
            n_checks++;
            if (rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL rdata_miss @%h: rdata=%h expected 0", a, rdata);
            end
            @(negedge clk); #1; cyc++;
        end
        n_checks++;
        if (dCacheMiss !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout @%h: dCacheMiss still %b after %0d cycles, expected 0", a, dCacheMiss, cyc);
        end
        if (exp_wb) ref_mem[wba] = wbd;
        if (exp_miss) begin
            m_valid[idx] = 1; m_dirty[idx] = 0; m_tag[idx] = tg; m_data[idx] = ref_line(ln);
        end
        l = m_data[idx];
        exp_rd = rw[1] ? 32'h0 : rw[0] ? 32'(l >> (32 * a[3:2])) : 32'($signed(8'(l >> (8 * a[3:0]))));
        n_checks++;
        if (rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL rdata @%h rw=%b: rdata=%h expected %h", a, rw, rdata, exp_rd);
        end
        last_rd  = rdata;
        last_cyc = cyc;
        if (rw[1]) begin
            sh   = rw[0] ? 32 * a[3:2] : 8 * a[3:0];
            mask = (rw[0] ? 128'hFFFF_FFFF : 128'hFF) << sh;
            m_data[idx]  = (l & ~mask) | ((128'(wd) << sh) & mask);
            m_dirty[idx] = 1;
        end
        n_checks++;
        if (wb_q_addr.size() != (exp_wb ? 1 : 0)) begin
            n_fail++;
            $display("FAIL wb_count @%h: writebacks=%0d expected %0d", a, wb_q_addr.size(), exp_wb);
        end else if (exp_wb && (wb_q_addr[0] !== wba || wb_q_data[0] !== wbd)) begin
            n_fail++;
            $display("FAIL wb_data @%h: got %h/%h expected %h/%h", a, wb_q_addr[0], wb_q_data[0], wba, wbd);
        end
        if (exp_wb && wb_q_addr.size() > 0) begin
            last_wb_addr = wb_q_addr[0];
            last_wb_data = wb_q_data[0];
        end
        n_checks++;
        if (fill_q.size() != (exp_miss ? 1 : 0) || (exp_miss && fill_q.size() > 0 && fill_q[0] !== ln)) begin
            n_fail++;
            $display("FAIL fill @%h: fills=%0d first=%h expected %0d at %h", a, fill_q.size(),
                     fill_q.size() > 0 ? fill_q[0] : 32'h0, exp_miss, ln);
        end
        @(posedge clk); #1;
    endtask

    task automatic model_invalidate();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; dc_req = 0; DC_rd_wr = 0; DC_we = 0; addr = 0; wdata = 0;
        model_invalidate();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: %h expected 0", rdata); end
        n_checks++;
        if (dCacheMiss !== 1'b0) begin n_fail++; $display("FAIL rst_miss: %b expected 0", dCacheMiss); end
        n_checks++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: %b expected 0", mem_req); end
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: %b expected 0", mem_we); end
        n_checks++;
        if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: %h expected 0", mem_addr); end
        n_checks++;
        if (mem_wdata !== 128'h0) begin n_fail++; $display("FAIL rst_wdata: %h expected 0", mem_wdata); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_directed();
        memm[32'h100]    = 128'h44444444_33333333_22222222_11111111;
        ref_mem[32'h100] = 128'h44444444_33333333_22222222_11111111;
        access(2'b01, 32'h100, 0);
        n_checks++;
        if (last_rd !== 32'h11111111 || last_cyc == 0) begin
            n_fail++; $display("FAIL cold_ldw: rdata=%h cycles=%0d expected 11111111 after a miss", last_rd, last_cyc);
        end
        access(2'b10, 32'h103, 32'h000000AB);
        access(2'b01, 32'h100, 0);
        n_checks++;
        if (last_rd !== 32'hAB111111) begin n_fail++; $display("FAIL stb_ldw: rdata=%h expected AB111111", last_rd); end
        n_checks++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL store_noreq: mem_req=%b expected 0", mem_req); end
        access(2'b00, 32'h103, 0);
        n_checks++;
        if (last_rd !== 32'hFFFFFFAB) begin n_fail++; $display("FAIL ldb_neg: rdata=%h expected FFFFFFAB", last_rd); end
        access(2'b00, 32'h100, 0);
        n_checks++;
        if (last_rd !== 32'h00000011) begin n_fail++; $display("FAIL ldb_pos: rdata=%h expected 00000011", last_rd); end
        access(2'b01, 32'h140, 0);
        n_checks++;
        if (last_wb_addr !== 32'h100 || last_wb_data[31:0] !== 32'hAB111111) begin
            n_fail++; $display("FAIL evict: wb addr=%h word0=%h expected 100/AB111111", last_wb_addr, last_wb_data[31:0]);
        end
    endtask

    task automatic test_reset_mid_fill();
        mem_auto = 0;
        @(negedge clk);
        dc_req = 1; DC_rd_wr = 2'b01; addr = 32'h200; DC_we = 0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200) begin
            n_fail++; $display("FAIL fill_req: req=%b we=%b addr=%h expected 1/0/200", mem_req, mem_we, mem_addr);
        end
        rst_n = 0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid: req=%b addr=%h expected 0/0", mem_req, mem_addr);
        end
        @(negedge clk);
        dc_req = 0;
        rst_n = 1;
        model_invalidate();
        mem_auto = 1;
        access(2'b01, 32'h100, 0);
        n_checks++;
        if (last_cyc == 0 || last_rd !== 32'hAB111111) begin
            n_fail++; $display("FAIL post_rst: cycles=%0d rdata=%h expected miss then AB111111", last_cyc, last_rd);
        end
    endtask

    task automatic test_ready_idle();
        @(posedge clk);
        dc_req = 0; DC_we = 0;
        pulse_req = 1;
        @(negedge clk);
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || dCacheMiss !== 1'b0) begin
            n_fail++; $display("FAIL idle_pulse: req=%b miss=%b expected 0/0", mem_req, dCacheMiss);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_after: req=%b expected 0", mem_req); end
        access(2'b01, 32'h104, 0);
        n_checks++;
        if (last_cyc != 0 || last_rd !== 32'h22222222) begin
            n_fail++; $display("FAIL idle_hit: cycles=%0d rdata=%h expected 0/22222222", last_cyc, last_rd);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++)
            access(2'($urandom_range(0, 3)), 32'($urandom_range(0, 1023)), $urandom);
    endtask

    task automatic test_back_to_back();
        access(2'b11, 32'h308, 32'h8000_00F0);
        access(2'b01, 32'h308, 0);
        access(2'b00, 32'h30B, 0);
        access(2'b10, 32'h309, 32'h0000_0077);
        access(2'b01, 32'h308, 0);
        n_checks++;
        if (last_rd !== 32'h8000_77F0) begin n_fail++; $display("FAIL b2b: rdata=%h expected 800077F0", last_rd); end
        access(2'b01, 32'h708, 0);
        access(2'b01, 32'h308, 0);
        n_checks++;
        if (last_rd !== 32'h8000_77F0) begin n_fail++; $display("FAIL b2b_reload: rdata=%h expected 800077F0", last_rd); end
        @(negedge clk);
        dc_req = 0; DC_we = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_fill();
        test_ready_idle();
        test_random();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
